// File: rtl/saddc_pkg.sv
// rtl/saddc_pkg.sv - sizes, node record, walker states and feature select for the tree walker
package saddc_pkg;
   localparam int NUM_FEATURES = 4;
   localparam int FEAT_W       = 32;
   localparam int FIDX_W       = $clog2(NUM_FEATURES);
   localparam int NODE_AW      = 6;
   localparam int CLASS_W      = 4;
   localparam int MAX_DEPTH    = 16;
   localparam int DEPTH_W      = $clog2(MAX_DEPTH + 1);

   typedef struct packed {
      logic               is_leaf;
      logic [FIDX_W-1:0]  feat_idx;
      logic [FEAT_W-1:0]  threshold;
      logic [NODE_AW-1:0] left;
      logic [NODE_AW-1:0] right;
      logic [CLASS_W-1:0] class_id;
   } node_t;

   localparam int NODE_W = $bits(node_t);

   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_ISSUE, ST_WAIT, ST_DONE} walk_state_t;

   // Out-of-range indices fall back to feature 0
   function automatic logic [FEAT_W-1:0] sel_feature(
      input logic [NUM_FEATURES*FEAT_W-1:0] feats,
      input logic [FIDX_W-1:0]              idx
   );
      if (int'(idx) >= NUM_FEATURES) return feats[FEAT_W-1:0];
      return feats[int'(idx)*FEAT_W +: FEAT_W];
   endfunction
endpackage

// File: rtl/saddc_tree_walker_if.sv
// rtl/saddc_tree_walker_if.sv - config, sample, result and comparator signals; SADDC_WALK_PERF_EN adds perf outputs
interface saddc_tree_walker_if;
   import saddc_pkg::*;

   logic                           cfg_valid;
   logic                           cfg_ready;
   logic [NODE_AW-1:0]             cfg_addr;
   logic [NODE_W-1:0]              cfg_node;
   logic                           io_req_valid;
   logic                           io_req_ready;
   logic [NUM_FEATURES*FEAT_W-1:0] io_req_bits_features;
   logic                           io_resp_valid;
   logic                           io_resp_ready;
   logic [CLASS_W-1:0]             io_resp_bits_class;
   logic                           io_resp_bits_error;
   logic                           cmp_req_valid;
   logic                           cmp_req_ready;
   logic [FEAT_W-1:0]              cmp_req_feature;
   logic [FEAT_W-1:0]              cmp_req_weights;
   logic                           cmp_resp_valid;
   logic                           cmp_resp_ready;
   logic                           cmp_resp_decision;
`ifdef SADDC_WALK_PERF_EN
   logic [DEPTH_W-1:0]             io_resp_bits_depth;
   logic [31:0]                    perf_cmp_count;
`endif

   modport slave (
      input  cfg_valid, cfg_addr, cfg_node, io_req_valid, io_req_bits_features, io_resp_ready,
             cmp_req_ready, cmp_resp_valid, cmp_resp_decision,
      output cfg_ready, io_req_ready, io_resp_valid, io_resp_bits_class, io_resp_bits_error,
             cmp_req_valid, cmp_req_feature, cmp_req_weights, cmp_resp_ready
`ifdef SADDC_WALK_PERF_EN
      , io_resp_bits_depth, perf_cmp_count
`endif
   );

   modport master (
      output cfg_valid, cfg_addr, cfg_node, io_req_valid, io_req_bits_features, io_resp_ready,
             cmp_req_ready, cmp_resp_valid, cmp_resp_decision,
      input  cfg_ready, io_req_ready, io_resp_valid, io_resp_bits_class, io_resp_bits_error,
             cmp_req_valid, cmp_req_feature, cmp_req_weights, cmp_resp_ready
`ifdef SADDC_WALK_PERF_EN
      , io_resp_bits_depth, perf_cmp_count
`endif
   );
endinterface

// File: rtl/saddc_node_mem.sv
// rtl/saddc_node_mem.sv - node table, one write port and one registered write-first read port
module saddc_node_mem
   import saddc_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [NODE_AW-1:0] i_waddr,
   input  node_t              i_wdata,
   input  logic [NODE_AW-1:0] i_raddr,
   output node_t              o_rdata
);
   node_t r_mem [2**NODE_AW];

   // Write-first so a write accepted alongside a sample is seen by the root fetch
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
   end
endmodule

// File: rtl/saddc_tree_walker.sv
// rtl/saddc_tree_walker.sv - walks the node table with one comparator per internal node; SADDC_WALK_PERF_EN adds depth and fire counters
module saddc_tree_walker
   import saddc_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   saddc_tree_walker_if.slave bus
);
   walk_state_t                    r_state, w_state_nxt;
   logic [NUM_FEATURES*FEAT_W-1:0] r_features;
   logic [FIDX_W-1:0]              r_feat_idx;
   logic [FEAT_W-1:0]              r_threshold;
   logic [NODE_AW-1:0]             r_left, r_right, w_rd_addr;
   logic [DEPTH_W-1:0]             r_depth;
   logic [CLASS_W-1:0]             r_class;
   logic                           r_error;
   node_t                          w_node;
   logic                           w_idle, w_req_fire, w_cfg_fire, w_at_limit;

   assign w_idle     = (r_state == ST_IDLE) && reset_n;
   assign w_req_fire = bus.io_req_valid && w_idle;
   assign w_cfg_fire = bus.cfg_valid && w_idle;
   assign w_at_limit = (r_depth == DEPTH_W'(MAX_DEPTH));

   saddc_node_mem u_node_mem (
      .i_clk   (clk),
      .i_we    (w_cfg_fire),
      .i_waddr (bus.cfg_addr),
      .i_wdata (node_t'(bus.cfg_node)),
      .i_raddr (w_rd_addr),
      .o_rdata (w_node)
   );

   assign bus.cfg_ready          = w_idle;
   assign bus.io_req_ready       = w_idle;
   assign bus.io_resp_valid      = (r_state == ST_DONE);
   assign bus.io_resp_bits_class = r_class;
   assign bus.io_resp_bits_error = r_error;
   assign bus.cmp_req_valid      = (r_state == ST_ISSUE);
   assign bus.cmp_req_feature    = sel_feature(r_features, r_feat_idx);
   assign bus.cmp_req_weights    = r_threshold;
   assign bus.cmp_resp_ready     = (r_state == ST_WAIT);

   // Node data is only consumed in FETCH, so the read address matters only on entry to it
   always_comb begin
      w_state_nxt = r_state;
      w_rd_addr   = '0;
      case (r_state)
         ST_IDLE:  if (w_req_fire) w_state_nxt = ST_FETCH;
         ST_FETCH: w_state_nxt = (w_node.is_leaf || w_at_limit) ? ST_DONE : ST_ISSUE;
         ST_ISSUE: if (bus.cmp_req_ready) w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            w_rd_addr = bus.cmp_resp_decision ? r_right : r_left;
            if (bus.cmp_resp_valid) w_state_nxt = ST_FETCH;
         end
         ST_DONE:  if (bus.io_resp_ready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_features  <= '0;
         r_feat_idx  <= '0;
         r_threshold <= '0;
         r_left      <= '0;
         r_right     <= '0;
         r_depth     <= '0;
         r_class     <= '0;
         r_error     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: if (w_req_fire) begin
               r_features <= bus.io_req_bits_features;
               r_depth    <= '0;
            end
            ST_FETCH: begin
               r_feat_idx  <= w_node.feat_idx;
               r_threshold <= w_node.threshold;
               r_left      <= w_node.left;
               r_right     <= w_node.right;
               r_class     <= w_node.is_leaf ? w_node.class_id : '0;
               r_error     <= !w_node.is_leaf && w_at_limit;
            end
            ST_WAIT: if (bus.cmp_resp_valid && !w_at_limit) r_depth <= r_depth + 1'b1;
            default: ;
         endcase
      end
   end

`ifdef SADDC_WALK_PERF_EN
   logic [31:0] r_perf_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_perf_cnt <= '0;
      else if (bus.cmp_req_valid && bus.cmp_req_ready && (r_perf_cnt != '1)) r_perf_cnt <= r_perf_cnt + 1'b1;
   end

   assign bus.io_resp_bits_depth = r_depth;
   assign bus.perf_cmp_count     = r_perf_cnt;
`endif
endmodule
